instr_fetch: RTL
================

Name: instr_fetch

Overview:
Fetch stage directly upstream of the main decoder. Holds the PC and fetches one instruction per step from instruction memory over a req/ack handshake of variable latency. Presents the instruction (full word plus ins_H/ins_L opcode/funct slices) to decode and holds it until the datapath retires it. Then computes the next PC from the decoder's Branch/PCSrc and the ALU zero flag.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous reset, active-high.
imem_req  out  1  fetch request, held until imem_ack.
imem_addr  out  32  byte address of fetch; equals pc while imem_req=1.
imem_ack  in  1  imem_rdata valid this cycle.
imem_rdata  in  32  fetched instruction word.
instr  out  32  registered current instruction.
ins_H  out  6  instr[31:26], to decoder.
ins_L  out  6  instr[5:0], to decoder.
instr_valid  out  1  instr/pc are valid for execution.
pc  out  32  address of instr.
exec_done  in  1  datapath retires current instruction this cycle.
Branch  in  1  from decoder (beq).
PCSrc  in  1  from decoder (jump).
alu_zero  in  1  ALU zero flag for current instruction.
retired  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, retired=0, state=FETCH. Reset asserted in any state aborts the fetch or issue. A late imem_ack after reset release with no outstanding request is ignored.
- FSM states:
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack, capture imem_rdata into instr and go to ISSUE. Ack may arrive in the first FETCH cycle (zero-wait memory).
  - ISSUE: imem_req=0, instr_valid=1. On exec_done, load next PC, increment retired, drop instr_valid and go to FETCH. Otherwise hold all outputs.
- Minimum instruction period is 2 cycles: FETCH with immediate ack, then ISSUE with immediate exec_done.
- imem_ack in ISSUE is ignored. exec_done in FETCH is ignored.
- Next PC, evaluated in ISSUE on exec_done, using pc4=pc+4 (mod 2^32):
  - PCSrc=1: {pc4[31:28], instr[25:0], 2'b00}. PCSrc has priority over Branch.
  - else Branch=1 and alu_zero=1: pc4 + (sign_extend(instr[15:0]) << 2), mod 2^32.
  - else: pc4.
- PC arithmetic wraps at 2^32. 0xFFFF_FFFC+4 gives 0. retired wraps to 0.
- pc[1:0] stays 00 by construction. No misalignment handling.
- instr retains its last value after retire until the next ack. Decode must qualify with instr_valid.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE=6'b000000, OP_J=6'b000010, OP_BEQ=6'b000100, OP_ADDI, OP_LW, OP_SW, OP_LWC1, OP_SWC1, OP_COP1;
  - field slice constants;
  - enum fetch_state_t {FETCH, ISSUE}.
- One sub-module, next_pc: purely combinational, computing next PC from pc, instr, Branch, PCSrc and alu_zero. It is reused for verification reference.

Test Plan:
- Reset then release, memory acks after 3 cycles with 0x20080005 -> imem_req=1 with imem_addr=0 for 3 cycles; then instr_valid=1, ins_H=6'b001000, pc=0. After exec_done, next imem_addr=0x4 and retired=1.
- Zero-wait ack with exec_done every ISSUE cycle -> each instruction takes exactly 2 cycles; addresses 0,4,8,C.
- pc=0x10, instr=0x10000003, Branch=1, alu_zero=1 -> next addr 0x20. Same with alu_zero=0 -> next addr 0x14.
- pc=0x20, instr offset 0xFFFF, Branch=1, alu_zero=1 -> next addr 0x20, i.e. a self-loop.
- pc=0x0040_0008, instr=0x0800_0040, PCSrc=1, Branch=1 -> next addr 0x0000_0100.
- Assert rst mid-FETCH while waiting for ack, then release -> imem_req restarts at RESET_PC and instr_valid stays 0. A stray imem_ack during ISSUE leaves instr unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, instruction field positions
// and the fetch FSM state type.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LWC1  = 6'b110001;
  localparam logic [5:0] OP_SWC1  = 6'b111001;
  localparam logic [5:0] OP_COP1  = 6'b010001;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int TGT_HI = 25;
  localparam int TGT_LO = 0;

  typedef enum logic {
    FETCH,
    ISSUE
  } fetch_state_t;

endpackage

// File: rtl/next_pc.sv
// Next-PC selection: jump, taken beq, or sequential.
// Jump wins over branch when the decoder raises both.
module next_pc
  import mips_pkg::*;
(
  input  logic [31:0]     pc,
  input  logic [TGT_HI:0] target,
  input  logic            branch,
  input  logic            pcsrc,
  input  logic            alu_zero,
  output logic [31:0]     npc
);

  logic [31:0] pc4;
  logic [31:0] boff;

  always_comb begin
    pc4  = pc + 32'd4;
    boff = {{14{target[IMM_HI]}}, target[IMM_HI:IMM_LO], 2'b00};
    npc  = pc4;
    if (pcsrc) begin
      npc = {pc4[31:28], target[TGT_HI:TGT_LO], 2'b00};
    end else if (branch && alu_zero) begin
      npc = pc4 + boff;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, imem req/ack handshake, instruction
// hold for decode until the datapath retires it.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic [5:0]       ins_H,
  output logic [5:0]       ins_L,
  output logic             instr_valid,
  output logic [31:0]      pc,
  input  logic             exec_done,
  input  logic             Branch,
  input  logic             PCSrc,
  input  logic             alu_zero,
  output logic [CNT_W-1:0] retired
);

  fetch_state_t     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic             req_q, req_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [31:0]      npc;

  next_pc u_next_pc (
    .pc       (pc_q),
    .target   (instr_q[TGT_HI:0]),
    .branch   (Branch),
    .pcsrc    (PCSrc),
    .alu_zero (alu_zero),
    .npc      (npc)
  );

  // req only rises one cycle after reset, so a stale ack is dropped
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ret_d   = ret_q;
    unique case (state_q)
      FETCH: begin
        if (req_q && imem_ack) begin
          instr_d = imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (exec_done) begin
          pc_d    = npc;
          ret_d   = ret_q + CNT_W'(1);
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
    req_d = (state_d == FETCH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      ret_q   <= ret_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign ins_H       = instr_q[OP_HI:OP_LO];
  assign ins_L       = instr_q[FN_HI:FN_LO];
  assign instr_valid = (state_q == ISSUE);
  assign retired     = ret_q;

endmodule
